// File: rtl/pc_update_unit.sv
// pc_update_unit
//   Program-counter register and next-PC sequencer for the single-cycle
//   RISC-V datapath. Selects the next PC from PC+4, branch/JAL or JALR
//   targets, handles stall and ECALL/EBREAK halt, traps misaligned
//   control-transfer targets into a sticky fault state and counts
//   retired instructions.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   pc_src        : 00/11 PC+4, 01 branch_target, 10 jalr_target
//   branch_target : PC-relative branch / JAL target
//   jalr_target   : rs1+imm sum for JALR (bit 0 cleared internally)
//   stall         : hold PC, no retire
//   halt_req      : current instruction is ECALL/EBREAK
//   resume        : leave HALT
//   pc_out        : current PC
//   pc_plus4      : pc_out + 4 (combinational, link value)
//   halted, fault : registered state decode
//   fault_pc      : PC of the faulting instruction
//   instret       : retired-instruction count
module pc_update_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            halted,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHalt  = 2'd1,
        StFault = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]     instret_q, instret_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] nxt;
    logic            nxt_misaligned;

    // Wraps modulo 2^XLEN naturally.
    assign pc_inc = pc_q + XLEN'(4);

    always_comb begin
        nxt = pc_inc;
        case (pc_src)
            2'b01:   nxt = branch_target;
            2'b10:   nxt = {jalr_target[XLEN-1:1], 1'b0};
            default: nxt = pc_inc;
        endcase
    end

    assign nxt_misaligned = (nxt[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        instret_d  = instret_q;

        case (state_q)
            StRun: begin
                if (!stall) begin
                    if (halt_req) begin
                        // ECALL/EBREAK retires and falls through to PC+4.
                        state_d   = StHalt;
                        pc_d      = pc_inc;
                        instret_d = instret_q + 32'd1;
                    end else if (nxt_misaligned) begin
                        state_d    = StFault;
                        fault_pc_d = pc_q;
                    end else begin
                        pc_d      = nxt;
                        instret_d = instret_q + 32'd1;
                    end
                end
            end
            StHalt: begin
                if (resume) begin
                    state_d = StRun;
                end
            end
            default: begin
                // StFault is sticky until reset.
                state_d = state_q;
            end
        endcase

        halted_d = (state_d == StHalt);
        fault_d  = (state_d == StFault);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
            instret_q  <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            instret_q  <= instret_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_plus4 = pc_inc;
    assign halted   = halted_q;
    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;
    assign instret  = instret_q;

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Program-counter register and next-PC sequencer for the single-cycle RISC-V datapath. It holds the architectural PC, picks the next PC from sequential, branch/JAL and JALR sources, and handles stall and halt (ECALL/EBREAK). It detects misaligned control-transfer targets and counts retired instructions. Its `pc_out` drives instruction memory and the PC-source and operand select multiplexers downstream.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (must be 4-byte aligned)

Ports:
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: asynchronous, active-high reset
- `pc_src` input 2: next-PC select; 00 = PC+4, 01 = `branch_target`, 10 = `jalr_target`, 11 = treated as 00
- `branch_target` input XLEN: PC-relative target for taken branch / JAL
- `jalr_target` input XLEN: rs1+imm sum for JALR
- `stall` input 1: hold PC this cycle, no retire
- `halt_req` input 1: current instruction is ECALL/EBREAK
- `resume` input 1: leave HALT state
- `pc_out` output XLEN: current PC
- `pc_plus4` output XLEN: `pc_out` + 4, combinational, for JAL/JALR link writeback
- `halted` output 1: high in HALT state
- `fault` output 1: high in FAULT state (sticky until reset)
- `fault_pc` output XLEN: PC of the instruction that caused the fault
- `instret` output 32: retired-instruction count

## Operation
- FSM states: RUN, HALT, FAULT. Reset state RUN.
- Candidate next PC (nxt):
  - 00/11 → `pc_out`+4
  - 01 → `branch_target`
  - 10 → `jalr_target` with bit 0 forced to 0
- Misaligned: nxt[1:0] != 2'b00 after the bit-0 clear.
- RUN, evaluated in priority order each edge:
  1. `stall`=1 → PC, instret and state all hold. `halt_req` and misalignment are ignored this cycle.
  2. `halt_req`=1 → go to HALT. PC advances to `pc_out`+4 regardless of `pc_src`. instret +1.
  3. nxt misaligned → go to FAULT. PC holds. `fault_pc` ← `pc_out`. instret unchanged.
  4. otherwise → PC ← nxt, instret +1.
- HALT:
  - PC and instret hold. `pc_src`, `stall` and `halt_req` are ignored.
  - `resume`=1 → RUN on next edge. No PC change on that edge.
- FAULT:
  - Everything holds. Only `rst` exits.
  - `resume` is ignored.
- Arithmetic:
  - PC+4 wraps modulo 2^XLEN (32'hFFFF_FFFC → 0).
  - instret wraps modulo 2^32 (32'hFFFF_FFFF → 0).
- Outputs:
  - `halted` = (state==HALT), `fault` = (state==FAULT), registered state decode.
  - `fault_pc` holds its last captured value until reset.

## Timing
- Reset (async assert, immediate): `pc_out`=RESET_PC, `pc_plus4`=RESET_PC+4, `halted`=0, `fault`=0, `fault_pc`=0, `instret`=0, state RUN.
- Reset deassertion: first update on the first rising edge with `rst`=0.
- Reset mid-operation: all registers return to reset values asynchronously, from any state.
- Latency:
  - Next-PC selection is combinational. The PC update takes effect one edge later.
  - `pc_plus4` tracks `pc_out` in the same cycle.
- Stall takes precedence over simultaneous halt or branch. Halt takes precedence over a simultaneous misaligned target.
- `resume` and `halt_req` high together in HALT → RUN for one cycle. A `halt_req` on that cycle halts again.

## Test plan
- Reset and sequential run: RESET_PC=0, `pc_src`=00 for 4 cycles → `pc_out` 0,4,8,C,10, `instret`=4, `halted`=`fault`=0.
- Branch and JALR:
  - `pc_src`=01, `branch_target`=32'h100 → `pc_out`=32'h100, `pc_plus4`=32'h104.
  - Then `pc_src`=10, `jalr_target`=32'h201 → `pc_out`=32'h200.
- Stall vs halt: `stall`=1 with `halt_req`=1 at PC=8 → PC stays 8, `instret` unchanged, `halted`=0.
- Halt then resume:
  - Next cycle `halt_req`=1 at PC=8 → `pc_out`=C, `halted`=1. It stays there 3 cycles with `pc_src`=01.
  - `resume`=1 → `halted`=0, PC still C.
- Misaligned fault:
  - PC=32'h40, `pc_src`=01, `branch_target`=32'h46 → `fault`=1, `fault_pc`=32'h40, PC stays 32'h40, `instret` frozen.
  - `resume` has no effect. Async `rst` pulse mid-cycle → `pc_out`=0, `fault`=0 immediately.
- Wrap-around: force PC to 32'hFFFF_FFFC, `pc_src`=00 → `pc_out`=0, no fault.
